// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types, encodings and helpers for the pipeline hazard controller
package core_pkg;

   localparam int REG_ADDR_W_DEF = 3;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   typedef enum logic [1:0] {
      HZ_RUN    = 2'b00,
      HZ_STALL  = 2'b01,
      HZ_FREEZE = 2'b10
   } hz_state_t;

   typedef struct packed {
      logic                      valid;
      logic [REG_ADDR_W_DEF-1:0] rd;
      logic                      reg_write;
      logic                      is_load;
   } sb_entry_t;

   // A load in EX cannot forward yet; an EX hit otherwise beats an older MEM hit.
   function automatic logic [1:0] fwd_select(input logic ex_hit,
                                             input logic ex_load,
                                             input logic mem_hit);
      if (ex_hit && !ex_load) return FWD_EXMEM;
      if (mem_hit)            return FWD_MEMWB;
      return FWD_REG;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID-stage decode fields in, pipeline control and forward selects out
interface hazard_ctrl_if #(
   parameter int REG_ADDR_W  = core_pkg::REG_ADDR_W_DEF,
   parameter int STALL_CNT_W = 16
);
   logic                   id_valid;
   logic [REG_ADDR_W-1:0]  id_rs1;
   logic [REG_ADDR_W-1:0]  id_rs2;
   logic                   id_use_rs1;
   logic                   id_use_rs2;
   logic [REG_ADDR_W-1:0]  id_rd;
   logic                   id_reg_write;
   logic                   id_load;
   logic                   id_jump;
   logic                   mem_busy;

   logic                   pc_stall;
   logic                   id_ex_bubble;
   logic                   if_id_flush;
   logic                   pipe_freeze;
   logic [STALL_CNT_W-1:0] stall_cnt;
   logic [1:0]             fwd_a;
   logic [1:0]             fwd_b;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
             id_reg_write, id_load, id_jump, mem_busy,
      input  pc_stall, id_ex_bubble, if_id_flush, pipe_freeze, stall_cnt, fwd_a, fwd_b
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
             id_reg_write, id_load, id_jump, mem_busy,
      output pc_stall, id_ex_bubble, if_id_flush, pipe_freeze, stall_cnt, fwd_a, fwd_b
   );
endinterface

// File: rtl/hz_scoreboard.sv
// rtl/hz_scoreboard.sv - in-flight destination tracking for EX and MEM with source-match outputs
module hz_scoreboard
   import core_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  freeze,
   input  logic                  bubble,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_load,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic                  id_use_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs2,
   output logic                  ex_hit_rs1,
   output logic                  ex_hit_rs2,
   output logic                  mem_hit_rs1,
   output logic                  mem_hit_rs2,
   output logic                  ex_is_load
);

   // The WB slot is not held: the register file writes in the first half of WB,
   // so an instruction there is already visible to ID and can never be a hazard.
   sb_entry_t ex_q;
   sb_entry_t mem_q;

   function automatic logic match(input sb_entry_t e,
                                  input logic [REG_ADDR_W-1:0] rs,
                                  input logic use_rs);
      return e.valid & e.reg_write & (e.rd == rs) & (rs != '0) & use_rs;
   endfunction

   // Advance EX->MEM and capture ID into EX unless the pipe is frozen; a bubble enters EX as invalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
      end else if (!freeze) begin
         mem_q <= ex_q;
         ex_q  <= '{valid:     id_valid & ~bubble,
                    rd:        id_rd,
                    reg_write: id_reg_write,
                    is_load:   id_load};
      end
   end

   assign ex_hit_rs1  = match(ex_q,  id_rs1, id_use_rs1);
   assign ex_hit_rs2  = match(ex_q,  id_rs2, id_use_rs2);
   assign mem_hit_rs1 = match(mem_q, id_rs1, id_use_rs1);
   assign mem_hit_rs2 = match(mem_q, id_rs2, id_use_rs2);
   assign ex_is_load  = ex_q.is_load;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RAW hazard stall, jump flush, memory freeze and stall counter; FORWARDING_EN enables operand forwarding
module hazard_ctrl
   import core_pkg::*;
#(
   parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
   parameter int STALL_CNT_W = 16
) (
   input logic          clk,
   input logic          rst_n,
   hazard_ctrl_if.slave hz
);

   logic                   ex_hit_rs1;
   logic                   ex_hit_rs2;
   logic                   mem_hit_rs1;
   logic                   mem_hit_rs2;
   logic                   ex_is_load;
   logic                   hazard;
   hz_state_t              state_q;
   hz_state_t              state_d;
   logic [STALL_CNT_W-1:0] cnt_q;

   hz_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_scoreboard (
      .clk          (clk),
      .rst_n        (rst_n),
      .freeze       (hz.pipe_freeze),
      .bubble       (hz.id_ex_bubble),
      .id_valid     (hz.id_valid),
      .id_rd        (hz.id_rd),
      .id_reg_write (hz.id_reg_write),
      .id_load      (hz.id_load),
      .id_rs1       (hz.id_rs1),
      .id_use_rs1   (hz.id_use_rs1),
      .id_rs2       (hz.id_rs2),
      .id_use_rs2   (hz.id_use_rs2),
      .ex_hit_rs1   (ex_hit_rs1),
      .ex_hit_rs2   (ex_hit_rs2),
      .mem_hit_rs1  (mem_hit_rs1),
      .mem_hit_rs2  (mem_hit_rs2),
      .ex_is_load   (ex_is_load)
   );

`ifdef FORWARDING_EN
   // Only a load still in EX has no value to forward yet: one-cycle load-use stall.
   assign hazard   = hz.id_valid & ex_is_load & (ex_hit_rs1 | ex_hit_rs2);
   assign hz.fwd_a = fwd_select(ex_hit_rs1, ex_is_load, mem_hit_rs1);
   assign hz.fwd_b = fwd_select(ex_hit_rs2, ex_is_load, mem_hit_rs2);
`else
   // Without bypass paths any producer in EX or MEM must drain first (up to 2 stall cycles).
   logic unused_ex_is_load;
   assign unused_ex_is_load = ex_is_load;
   assign hazard   = hz.id_valid & (ex_hit_rs1 | ex_hit_rs2 | mem_hit_rs1 | mem_hit_rs2);
   assign hz.fwd_a = FWD_REG;
   assign hz.fwd_b = FWD_REG;
`endif

   // Pipeline controls by priority: memory freeze, then data hazard, then jump flush.
   always_comb begin
      hz.pc_stall     = 1'b0;
      hz.id_ex_bubble = 1'b0;
      hz.if_id_flush  = 1'b0;
      hz.pipe_freeze  = 1'b0;
      state_d         = HZ_RUN;
      if (hz.mem_busy) begin
         hz.pipe_freeze = 1'b1;
         hz.pc_stall    = 1'b1;
         state_d        = HZ_FREEZE;
      end else if (hazard) begin
         hz.pc_stall     = 1'b1;
         hz.id_ex_bubble = 1'b1;
         state_d         = HZ_STALL;
      end else if (hz.id_valid && hz.id_jump) begin
         hz.if_id_flush = 1'b1;
      end
   end

   // Sequencer state tracks which kind of stall the pipe sat in last cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= HZ_RUN;
      else        state_q <= state_d;
   end

   // Saturating count of cycles spent stalled or frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (state_q != HZ_RUN && cnt_q != {STALL_CNT_W{1'b1}}) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign hz.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed pipeline sequences
module tb_hazard_ctrl;

   logic clk;
   logic rst_n;

   hazard_ctrl_if #(.REG_ADDR_W(3), .STALL_CNT_W(4)) hz_if ();

   hazard_ctrl #(.REG_ADDR_W(3), .STALL_CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      nm;
      logic [11:0] v;   // {pc_stall, bubble, flush, freeze, fwd_a, fwd_b, stall_cnt}
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic set_id(input bit v, input bit [2:0] rs1, input bit u1,
                         input bit [2:0] rs2, input bit u2, input bit [2:0] rd,
                         input bit rw, input bit ld, input bit jmp);
      hz_if.id_valid     = v;
      hz_if.id_rs1       = rs1;
      hz_if.id_use_rs1   = u1;
      hz_if.id_rs2       = rs2;
      hz_if.id_use_rs2   = u2;
      hz_if.id_rd        = rd;
      hz_if.id_reg_write = rw;
      hz_if.id_load      = ld;
      hz_if.id_jump      = jmp;
   endtask

   task automatic idle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic expect_out(input string nm, input bit ps, input bit bub, input bit fl,
                             input bit fr, input bit [1:0] fa, input bit [1:0] fb,
                             input bit [3:0] cnt);
      exp_t e;
      e.nm = nm;
      e.v  = {ps, bub, fl, fr, fa, fb, cnt};
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string nm);
      rst_n = 1'b0;
      idle();
      hz_if.mem_busy = 1'b0;
      tick();
      expect_out(nm, 0, 0, 0, 0, 2'b00, 2'b00, 4'd0);
      tick();
      rst_n = 1'b1;
   endtask

   // Monitor: every cycle with a pending expectation, compare the DUT outputs mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [11:0] act;
         e   = exp_q.pop_front();
         act = {hz_if.pc_stall, hz_if.id_ex_bubble, hz_if.if_id_flush, hz_if.pipe_freeze,
                hz_if.fwd_a, hz_if.fwd_b, hz_if.stall_cnt};
         n_tests++;
         if (act !== e.v) begin
            n_fail++;
            $display("FAIL %s: got stall/bub/flush/frz=%b fwd_a=%b fwd_b=%b cnt=%0d, expected stall/bub/flush/frz=%b fwd_a=%b fwd_b=%b cnt=%0d",
                     e.nm, act[11:8], act[7:6], act[5:4], act[3:0],
                     e.v[11:8], e.v[7:6], e.v[5:4], e.v[3:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int c;
      clk = 1'b0;
      rst_n = 1'b0;
      idle();
      hz_if.mem_busy = 1'b0;
      do_reset("reset_state");

      // ADD r1 then dependent ADD r2,r1,r3
      set_id(1, 3'd2, 1, 3'd3, 1, 3'd1, 1, 0, 0);
      expect_out("t1_producer", 0, 0, 0, 0, 2'b00, 2'b00, 4'd0); tick();
      set_id(1, 3'd1, 1, 3'd3, 1, 3'd2, 1, 0, 0);
`ifdef FORWARDING_EN
      expect_out("t2_fwd_ex", 0, 0, 0, 0, 2'b01, 2'b00, 4'd0); tick();
      set_id(1, 3'd3, 1, 3'd1, 1, 3'd3, 1, 0, 0);
      expect_out("t2_fwd_mem", 0, 0, 0, 0, 2'b00, 2'b10, 4'd0); tick();
      idle();
      expect_out("t2_no_cnt", 0, 0, 0, 0, 2'b00, 2'b00, 4'd0); tick();
`else
      expect_out("t1_stall_ex", 1, 1, 0, 0, 2'b00, 2'b00, 4'd0); tick();
      expect_out("t1_stall_mem", 1, 1, 0, 0, 2'b00, 2'b00, 4'd0); tick();
      expect_out("t1_release", 0, 0, 0, 0, 2'b00, 2'b00, 4'd1); tick();
      idle();
      expect_out("t1_cnt2", 0, 0, 0, 0, 2'b00, 2'b00, 4'd2); tick();
`endif

      // LOAD r4 then consumer of r4
      do_reset("reset_t3");
      set_id(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 1, 0);
      expect_out("t3_load", 0, 0, 0, 0, 2'b00, 2'b00, 4'd0); tick();
      set_id(1, 3'd4, 1, 3'd5, 1, 3'd6, 1, 0, 0);
      expect_out("t3_stall_1", 1, 1, 0, 0, 2'b00, 2'b00, 4'd0); tick();
`ifdef FORWARDING_EN
      expect_out("t3_fwd_mem", 0, 0, 0, 0, 2'b10, 2'b00, 4'd0); tick();
      idle();
      expect_out("t3_cnt1", 0, 0, 0, 0, 2'b00, 2'b00, 4'd1); tick();
`else
      expect_out("t3_stall_2", 1, 1, 0, 0, 2'b00, 2'b00, 4'd0); tick();
      expect_out("t3_release", 0, 0, 0, 0, 2'b00, 2'b00, 4'd1); tick();
      idle();
      expect_out("t3_cnt2", 0, 0, 0, 0, 2'b00, 2'b00, 4'd2); tick();
`endif

      // Jump alone, then jump held behind a 3-cycle memory freeze
      do_reset("reset_t4");
      set_id(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1);
      expect_out("t4_flush", 0, 0, 1, 0, 2'b00, 2'b00, 4'd0); tick();
      idle();
      expect_out("t4_flush_once", 0, 0, 0, 0, 2'b00, 2'b00, 4'd0); tick();
      set_id(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1);
      hz_if.mem_busy = 1'b1;
      expect_out("t4_freeze_1", 1, 0, 0, 1, 2'b00, 2'b00, 4'd0); tick();
      expect_out("t4_freeze_2", 1, 0, 0, 1, 2'b00, 2'b00, 4'd0); tick();
      expect_out("t4_freeze_3", 1, 0, 0, 1, 2'b00, 2'b00, 4'd1); tick();
      hz_if.mem_busy = 1'b0;
      expect_out("t4_release_flush", 0, 0, 1, 0, 2'b00, 2'b00, 4'd2); tick();
      idle();
      expect_out("t4_cnt3", 0, 0, 0, 0, 2'b00, 2'b00, 4'd3); tick();
      expect_out("t4_cnt3_hold", 0, 0, 0, 0, 2'b00, 2'b00, 4'd3); tick();

      // r0 never creates a hazard
      do_reset("reset_t5");
      set_id(1, 3'd1, 1, 3'd2, 1, 3'd0, 1, 0, 0);
      expect_out("t5_r0_prod", 0, 0, 0, 0, 2'b00, 2'b00, 4'd0); tick();
      set_id(1, 3'd0, 1, 3'd0, 1, 3'd3, 1, 0, 0);
      expect_out("t5_r0_cons", 0, 0, 0, 0, 2'b00, 2'b00, 4'd0); tick();
      idle();
      expect_out("t5_r0_idle", 0, 0, 0, 0, 2'b00, 2'b00, 4'd0); tick();

      // Load r5, consumer frozen 2 cycles, then async reset during the load-use stall
      set_id(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1, 0);
      expect_out("t5_load", 0, 0, 0, 0, 2'b00, 2'b00, 4'd0); tick();
      set_id(1, 3'd5, 1, 3'd5, 1, 3'd6, 1, 0, 0);
      hz_if.mem_busy = 1'b1;
      expect_out("t5_freeze_1", 1, 0, 0, 1, 2'b00, 2'b00, 4'd0); tick();
      expect_out("t5_freeze_2", 1, 0, 0, 1, 2'b00, 2'b00, 4'd0); tick();
      hz_if.mem_busy = 1'b0;
      expect_out("t5_async_reset", 0, 0, 0, 0, 2'b00, 2'b00, 4'd0);
      #2 rst_n = 1'b0;
      tick();
      expect_out("t5_reset_hold", 0, 0, 0, 0, 2'b00, 2'b00, 4'd0);
      tick();
      rst_n = 1'b1;
      idle();

      // Long freeze saturates the 4-bit counter
      do_reset("reset_t6");
      hz_if.mem_busy = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         c = (k < 2) ? 0 : k - 2;
         if (c > 15) c = 15;
         expect_out($sformatf("t6_freeze_%0d", k), 1, 0, 0, 1, 2'b00, 2'b00, 4'(c));
         tick();
      end
      hz_if.mem_busy = 1'b0;
      expect_out("t6_sat_release", 0, 0, 0, 0, 2'b00, 2'b00, 4'hF); tick();
      expect_out("t6_sat_hold", 0, 0, 0, 0, 2'b00, 2'b00, 4'hF); tick();

      repeat (3) @(negedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
